// File: rtl/csr_pkg.sv
// CSR address map and address type shared by the GPIO CSR file and the
// decode-stage control logic.
package csr_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t GPIO_IN   = 12'hF00;
    localparam csr_addr_t GPIO_OUT0 = 12'hF02;
    localparam csr_addr_t GPIO_OUT1 = 12'hF03;
    localparam csr_addr_t CYCLE     = 12'hB00;
    localparam csr_addr_t CYCLEH    = 12'hB80;
    localparam csr_addr_t INSTRET   = 12'hB02;
    localparam csr_addr_t INSTRETH  = 12'hB82;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for asynchronous GPIO inputs.
// Ports: clk, rst_n (sync, active-low), d (async in), q (synchronized out).
module gpio_sync #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_stage[i] <= '0;
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++)
                r_stage[i] <= r_stage[i-1];
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/csr_gpio_file.sv
// GPIO-mapped CSR file: synchronized GPIO_IN, two RW output registers,
// and optional 64-bit cycle/instret counters (macro CSR_COUNTERS_EN).
// Ports: clk, rst_n (sync, active-low); csr_en, gpio_we, csr_addr,
// csr_wdata, stall, retire (access); gpio_in (async pins);
// csr_rdata (old value, combinational), gpio_out0/1, csr_illegal.
module csr_gpio_file
    import csr_pkg::*;
#(
    parameter logic [31:0] GPIO_OUT_RST = 32'h0000_0000,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_en,
    input  logic        gpio_we,
    input  csr_addr_t   csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        stall,
    input  logic        retire,
    input  logic [31:0] gpio_in,
    output logic [31:0] csr_rdata,
    output logic [31:0] gpio_out0,
    output logic [31:0] gpio_out1,
    output logic        csr_illegal
);

    logic [31:0] r_out0;
    logic [31:0] r_out1;
    logic [31:0] w_gpio_in;
    logic        w_wr;
    logic        w_we0;
    logic        w_we1;
    logic        w_hit;
    logic [31:0] w_rdata;

    gpio_sync #(
        .DEPTH (SYNC_STAGES),
        .W     (32)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (gpio_in),
        .q     (w_gpio_in)
    );

    assign w_wr  = csr_en & gpio_we & ~stall;
    assign w_we0 = w_wr & (csr_addr == GPIO_OUT0);
    assign w_we1 = w_wr & (csr_addr == GPIO_OUT1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out0 <= GPIO_OUT_RST;
            r_out1 <= GPIO_OUT_RST;
        end else begin
            if (w_we0)
                r_out0 <= csr_wdata;
            if (w_we1)
                r_out1 <= csr_wdata;
        end
    end

    assign gpio_out0 = r_out0;
    assign gpio_out1 = r_out1;

`ifdef CSR_COUNTERS_EN
    logic [63:0] r_cycle;
    logic [63:0] r_instret;

    // Both counters wrap silently through natural 64-bit overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (retire && !stall)
                r_instret <= r_instret + 64'd1;
        end
    end
`else
    logic w_unused_retire;
    assign w_unused_retire = retire;
`endif

    // Reads see register state before this cycle's edge, so a
    // same-cycle write returns the old value.
    always_comb begin
        w_rdata = '0;
        w_hit   = 1'b1;
        unique case (csr_addr)
            GPIO_IN:   w_rdata = w_gpio_in;
            GPIO_OUT0: w_rdata = r_out0;
            GPIO_OUT1: w_rdata = r_out1;
`ifdef CSR_COUNTERS_EN
            CYCLE:     w_rdata = r_cycle[31:0];
            CYCLEH:    w_rdata = r_cycle[63:32];
            INSTRET:   w_rdata = r_instret[31:0];
            INSTRETH:  w_rdata = r_instret[63:32];
`endif
            default:   w_hit = 1'b0;
        endcase
    end

    assign csr_rdata   = csr_en ? w_rdata : 32'h0;
    assign csr_illegal = csr_en & ~w_hit;

endmodule

// File: doc/csr_gpio_file.md
CSR_GPIO_FILE -- requirements
Module: csr_gpio_file

Interface
REQ-001 Parameter GPIO_OUT_RST, default 32'h0000_0000: reset value of both GPIO output registers.
REQ-002 Parameter SYNC_STAGES, default 2, legal 2..3: flop depth of the gpio_in synchronizer.
REQ-003 Clock, reset and pins:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
REQ-004 Access ports:
- csr_en  input  1  CSRRW access this cycle.
- gpio_we  input  1  write strobe for GPIO-mapped CSR.
- csr_addr  input  12  CSR address.
- csr_wdata  input  32  rs1 value.
- stall  input  1  suppresses all writes and instret counting.
- retire  input  1  one instruction retires this cycle.
REQ-005 GPIO and readback ports:
- gpio_in  input  32  asynchronous switch inputs.
- csr_rdata  output  32  old CSR value for rd.
- gpio_out0  output  32  register at 0xF02.
- gpio_out1  output  32  register at 0xF03.
- csr_illegal  output  1  access to an unmapped address.

Function
REQ-006 Address map: 0xF00 GPIO_IN (RO, synchronized); 0xF02 GPIO_OUT0 (RW); 0xF03 GPIO_OUT1 (RW); 0xB00/0xB80 cycle low/high (RO); 0xB02/0xB82 instret low/high (RO).
REQ-007 csr_rdata: combinational from csr_addr and current register state, zero-latency; 32'h0 when csr_en=0 or the address is unmapped.
REQ-008 GPIO_OUTn write condition: csr_en & gpio_we & !stall & csr_addr==0xF02/0xF03.
REQ-009 On a write, csr_wdata lands at the next rising edge and is visible on gpio_outN and csr_rdata one cycle after the access.
REQ-010 A same-cycle read and write of one CSR returns the old value on csr_rdata.
REQ-011 Writes to RO addresses are silently ignored and do not assert csr_illegal.
REQ-012 gpio_out0 and gpio_out1 are driven directly from their registers, with no combinational path from inputs.
REQ-013 gpio_in passes through a SYNC_STAGES flop chain; a change is readable at 0xF00 exactly SYNC_STAGES cycles later.
REQ-014 Cycle counter: 64-bit, increments by 1 every cycle rst_n=1, regardless of stall.
REQ-015 Instret counter: 64-bit, increments by 1 when retire & !stall.
REQ-016 Both counters wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
REQ-017 Counter reads return the pre-increment value of the current cycle.
REQ-018 csr_illegal: combinational, = csr_en & address not in the REQ-006 map.
REQ-019 gpio_we asserted with an address other than 0xF02/0xF03 writes nothing.

Reset
REQ-020 When rst_n=0 at a rising edge: gpio_out0/1 go to GPIO_OUT_RST; synchronizer flops, cycle and instret go to 0.
REQ-021 Reset has priority over any simultaneous write or increment.
REQ-022 With rst_n=0, csr_rdata and csr_illegal still follow REQ-007/REQ-018 against the reset state.
REQ-023 The cycle counter reads 0 in the first cycle after rst_n deasserts and 1 in the next.

Configuration
REQ-024 Macro CSR_COUNTERS_EN: when defined, the cycle/instret counters and their four addresses exist.
REQ-025 When CSR_COUNTERS_EN is undefined: no counter flops; 0xB00/0xB80/0xB02/0xB82 are unmapped, reading 0 and asserting csr_illegal on access.

Structure
REQ-026 Shared package csr_pkg holds the CSR address localparams (GPIO_IN, GPIO_OUT0/1, CYCLE/CYCLEH, INSTRET/INSTRETH) and the 12-bit csr_addr_t typedef, shared with the decode-stage control logic.
REQ-027 One sub-module, gpio_sync: parameterized-depth, width-32 synchronizer with synchronous active-low reset.

Verification
REQ-028 Reset then csr_en=1, gpio_we=1, addr=0xF02, wdata=32'hDEAD_BEEF -> rdata=0 that cycle; gpio_out0=32'hDEAD_BEEF next cycle.
REQ-029 Same write with stall=1 -> gpio_out0 stays at GPIO_OUT_RST; instret does not advance while retire=1.
REQ-030 gpio_in 0->32'h0000_00A5, read 0xF00 each cycle -> 0 for SYNC_STAGES cycles, then 32'h0000_00A5.
REQ-031 Counters preloaded via force to 64'hFFFF_FFFF_FFFF_FFFF -> next cycle 0xB00 and 0xB80 both read 0.
REQ-032 csr_en=1, addr=0x123 -> csr_illegal=1, rdata=0, no state change; rebuild without CSR_COUNTERS_EN, addr=0xB00 -> csr_illegal=1.
REQ-033 rst_n=0 asserted in the cycle of a 0xF03 write -> gpio_out1=GPIO_OUT_RST and cycle=0 next cycle.
